// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the 3-bit sequence checker.
package seq_pkg;

  localparam int SEQ_W       = 3;
  localparam int LEN_DEFAULT = 6;

  // Element i lives at bits [3i+2:3i]; default period is 0,1,3,7,6,4.
  localparam logic [SEQ_W*LEN_DEFAULT-1:0] SEQ_DEFAULT =
    {3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker for a cyclic 3-bit sequence: lock, flywheel tracking,
// mismatch/period flags and a saturating error count.
// Optional: define SEQ_CHK_RESYNC_EN to lock on any element of the sequence.
module seq_checker
  import seq_pkg::*;
#(
  parameter int                     LEN         = LEN_DEFAULT,
  parameter logic [SEQ_W*LEN-1:0]   SEQ         = SEQ_DEFAULT,
  parameter int                     LOSS_THRESH = 2,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SEQ_W-1:0] seq_in,
  output logic             locked,
  output logic             mismatch,
  output logic             period_done,
  output logic [CNT_W-1:0] err_count,
  output logic [SEQ_W-1:0] expected
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [MISS_W-1:0]  miss_run, miss_next;
  logic               mismatch_next, period_next;

  function automatic logic [SEQ_W-1:0] elem(input int i);
    return SEQ[SEQ_W*i +: SEQ_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(LEN - 1)) ? '0 : i + IDX_W'(1);
  endfunction

`ifdef SEQ_CHK_RESYNC_EN
  logic             hit;
  logic [IDX_W-1:0] hit_k;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    miss_next     = miss_run;
    mismatch_next = 1'b0;
    period_next   = 1'b0;
`ifdef SEQ_CHK_RESYNC_EN
    hit   = 1'b0;
    hit_k = '0;
`endif
    if (in_valid) begin
      unique case (state)
        SEARCH: begin
`ifdef SEQ_CHK_RESYNC_EN
          // Lowest matching position wins when the sequence repeats a value.
          for (int k = 0; k < LEN; k++) begin
            if (!hit && (seq_in == elem(k))) begin
              hit   = 1'b1;
              hit_k = IDX_W'(k);
            end
          end
          if (hit) begin
            state_next  = TRACK;
            idx_next    = idx_inc(hit_k);
            miss_next   = '0;
            period_next = (hit_k == IDX_W'(LEN - 1));
          end
`else
          if (seq_in == elem(0)) begin
            state_next  = TRACK;
            idx_next    = idx_inc('0);
            miss_next   = '0;
            period_next = (LEN == 1);
          end
`endif
        end
        TRACK: begin
          idx_next = idx_inc(idx);
          if (seq_in == elem(int'(idx))) begin
            miss_next   = '0;
            period_next = (idx == IDX_W'(LEN - 1));
          end else begin
            mismatch_next = 1'b1;
            if (miss_run + MISS_W'(1) == MISS_W'(LOSS_THRESH)) begin
              state_next = SEARCH;
              idx_next   = '0;
              miss_next  = '0;
            end else begin
              miss_next = miss_run + MISS_W'(1);
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SEARCH;
      idx         <= '0;
      miss_run    <= '0;
      mismatch    <= 1'b0;
      period_done <= 1'b0;
      expected    <= elem(0);
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      miss_run    <= miss_next;
      mismatch    <= mismatch_next;
      period_done <= period_next;
      expected    <= elem(int'(idx_next));
    end
  end

  assign locked = (state == TRACK);

  seq_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clear (~reset),
    .inc   (mismatch_next),
    .count (err_count)
  );

endmodule
